// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - core opcode constants and instruction-type codes shared by fetch and decode
package fetch_unit_pkg;

    localparam logic [6:0] OPC_EOF    = 7'b1110011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FP     = 7'b1010011;
    localparam logic [6:0] OPC_FLW    = 7'b0000111;
    localparam logic [6:0] OPC_FSW    = 7'b0100111;

    typedef enum logic [2:0] {
        ITYPE_R,
        ITYPE_I,
        ITYPE_S,
        ITYPE_B,
        ITYPE_U,
        ITYPE_J,
        ITYPE_SYS
    } instr_type_t;

    function automatic logic is_eof(input logic [6:0] opcode);
        return opcode == OPC_EOF;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory port and decoder handshake of the fetch stage
interface fetch_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              o_imem_cen;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [31:0]       i_imem_rdata;
    logic [31:0]       o_instr;
    logic [ADDR_W-1:0] o_pc;
    logic              o_instr_valid;
    logic              i_instr_ready;
    logic              i_redirect_valid;
    logic [ADDR_W-1:0] i_redirect_pc;

    modport master (
        output o_imem_cen,
        output o_imem_addr,
        input  i_imem_rdata,
        output o_instr,
        output o_pc,
        output o_instr_valid,
        input  i_instr_ready,
        input  i_redirect_valid,
        input  i_redirect_pc
    );

    modport slave (
        input  o_imem_cen,
        input  o_imem_addr,
        output i_imem_rdata,
        input  o_instr,
        input  o_pc,
        input  o_instr_valid,
        output i_instr_ready,
        output i_redirect_valid,
        output i_redirect_pc
    );
endinterface

// File: rtl/fetch_addr_chk.sv
// rtl/fetch_addr_chk.sv - combinational legality check of a fetch address
module fetch_addr_chk #(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    IMEM_BASE  = '0,
    parameter int unsigned          IMEM_BYTES = 4096
) (
    input  logic [ADDR_W-1:0] pc,
    output logic              legal
);

    localparam logic [ADDR_W:0] BASE_EXT  = {1'b0, IMEM_BASE};
    localparam logic [ADDR_W:0] BYTES_EXT = (ADDR_W+1)'(IMEM_BYTES);

    logic [ADDR_W:0] offset;

    // Offset into the fetch window one bit wider than pc; a borrow means pc is below the base.
    always_comb begin
        offset = {1'b0, pc} - BASE_EXT;
        legal  = (pc[1:0] == 2'b00) && !offset[ADDR_W] && (offset < BYTES_EXT);
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem reads, decoder handshake, redirects, halt
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    IMEM_BASE  = '0,
    parameter int unsigned          IMEM_BYTES = 4096,
    parameter int unsigned          RD_LAT     = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    fetch_unit_if.master bus,
    output logic         o_halted,
    output logic         o_fetch_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALT,
        ST_ERR
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [1:0]        lat_cnt;
    logic              accept;
    logic              nxt_legal;

    assign accept = (state == ST_HOLD) && bus.i_instr_ready;

    // Next PC: only an accepted instruction moves it, to the redirect target or the sequential word.
    always_comb begin
        pc_nxt = pc;
        if (accept) begin
            pc_nxt = bus.i_redirect_valid ? bus.i_redirect_pc : pc + ADDR_W'(4);
        end
    end

    fetch_addr_chk #(
        .ADDR_W     (ADDR_W),
        .IMEM_BASE  (IMEM_BASE),
        .IMEM_BYTES (IMEM_BYTES)
    ) u_addr_chk (
        .pc    (pc_nxt),
        .legal (nxt_legal)
    );

    // Fetch FSM; the strobe is decided on entry to REQ so REQ itself only routes to WAIT or ERR.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state             <= ST_IDLE;
            pc                <= IMEM_BASE;
            lat_cnt           <= '0;
            bus.o_imem_cen    <= 1'b0;
            bus.o_imem_addr   <= '0;
            bus.o_instr       <= '0;
            bus.o_pc          <= '0;
            bus.o_instr_valid <= 1'b0;
            o_halted          <= 1'b0;
            o_fetch_err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.o_imem_cen  <= nxt_legal;
                    bus.o_imem_addr <= pc_nxt;
                    state           <= ST_REQ;
                end
                ST_REQ: begin
                    bus.o_imem_cen <= 1'b0;
                    if (bus.o_imem_cen) begin
                        lat_cnt <= LAT_INIT;
                        state   <= ST_WAIT;
                    end else begin
                        o_fetch_err <= 1'b1;
                        state       <= ST_ERR;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        bus.o_instr       <= bus.i_imem_rdata;
                        bus.o_pc          <= pc;
                        bus.o_instr_valid <= 1'b1;
                        state             <= ST_HOLD;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                ST_HOLD: begin
                    if (bus.i_instr_ready) begin
                        bus.o_instr_valid <= 1'b0;
                        if (is_eof(bus.o_instr[6:0])) begin
                            o_halted <= 1'b1;
                            state    <= ST_HALT;
                        end else begin
                            pc              <= pc_nxt;
                            bus.o_imem_cen  <= nxt_legal;
                            bus.o_imem_addr <= pc_nxt;
                            state           <= ST_REQ;
                        end
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                ST_ERR: begin
                    state <= ST_ERR;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit at read latencies 1, 3 and 4
module tb_fetch_unit;

    localparam int NL = 3;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 4;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [NL];
    logic        ready [NL];
    logic        rdv   [NL];
    logic [31:0] rpc   [NL];

    wire         cen_w    [NL];
    wire  [31:0] addr_w   [NL];
    wire  [31:0] instr_w  [NL];
    wire  [31:0] opc_w    [NL];
    wire         valid_w  [NL];
    wire         halted_w [NL];
    wire         err_w    [NL];

    logic [31:0] mem [1024];

    int checks   = 0;
    int failures = 0;

    for (genvar k = 0; k < NL; k++) begin : g_lane
        fetch_unit_if #(.ADDR_W(32)) bus ();

        fetch_unit #(
            .ADDR_W     (32),
            .IMEM_BASE  (32'h0),
            .IMEM_BYTES (4096),
            .RD_LAT     (lat_of(k))
        ) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n[k]),
            .bus         (bus),
            .o_halted    (halted_w[k]),
            .o_fetch_err (err_w[k])
        );

        logic [32:0] pipe [4];
        always @(posedge clk) begin
            pipe[0] <= {bus.o_imem_cen, bus.o_imem_addr};
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end

        assign bus.i_imem_rdata     = pipe[lat_of(k)-1][32] ? mem[pipe[lat_of(k)-1][11:2]] : 32'hDEAD_BEEF;
        assign bus.i_instr_ready    = ready[k];
        assign bus.i_redirect_valid = rdv[k];
        assign bus.i_redirect_pc    = rpc[k];
        assign cen_w[k]   = bus.o_imem_cen;
        assign addr_w[k]  = bus.o_imem_addr;
        assign instr_w[k] = bus.o_instr;
        assign opc_w[k]   = bus.o_pc;
        assign valid_w[k] = bus.o_instr_valid;
    end

    task automatic chk_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_list(input string nm, input int act[$], input int exp[$]);
        chk_val({nm, "_len"}, act.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk_val($sformatf("%s[%0d]", nm, i), (i < act.size()) ? act[i] : -1, exp[i]);
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'd4096);
    endfunction

    // Event-timed model: each fetch is a strobe cycle plus a fixed data delay, per lane.
    int          mc        [NL];
    int          strobe_at [NL];
    int          mode      [NL];
    logic [31:0] m_pc      [NL];
    logic [31:0] last_acc  [NL];
    bit          rst_seen  [NL] = '{1, 1, 1};
    bit          prev_v    [NL];

    int act_lane = 0;
    int s_cyc[$], s_addr[$], a_cyc[$], a_pc[$], rise_cyc[$];
    int halt_cyc = -1;

    always @(negedge clk) begin
        for (int k = 0; k < NL; k++) begin
            if (rst_seen[k]) begin
                chk_val($sformatf("L%0d_rst_cen", k), cen_w[k], 0);
                chk_val($sformatf("L%0d_rst_addr", k), addr_w[k], 0);
                chk_val($sformatf("L%0d_rst_instr", k), instr_w[k], 0);
                chk_val($sformatf("L%0d_rst_pc", k), opc_w[k], 0);
                chk_val($sformatf("L%0d_rst_valid", k), valid_w[k], 0);
                chk_val($sformatf("L%0d_rst_halted", k), halted_w[k], 0);
                chk_val($sformatf("L%0d_rst_err", k), err_w[k], 0);
                mc[k] = 0; strobe_at[k] = 1; mode[k] = 0;
                m_pc[k] = 0; last_acc[k] = 0; prev_v[k] = 0;
            end else begin
                int  c;
                bit  e_cen, e_valid;
                mc[k]++;
                c = mc[k];
                e_cen   = (mode[k] == 0) && (c == strobe_at[k]) && legal(m_pc[k]);
                e_valid = (mode[k] == 0) && (c >= strobe_at[k] + lat_of(k) + 1) && legal(m_pc[k]);
                chk_val($sformatf("L%0d_c%0d_cen", k, c), cen_w[k], e_cen);
                chk_val($sformatf("L%0d_c%0d_valid", k, c), valid_w[k], e_valid);
                chk_val($sformatf("L%0d_c%0d_halted", k, c), halted_w[k], mode[k] == 1);
                chk_val($sformatf("L%0d_c%0d_err", k, c), err_w[k], mode[k] == 2);
                if (e_cen) chk_val($sformatf("L%0d_c%0d_addr", k, c), addr_w[k], m_pc[k]);
                if (e_valid) begin
                    chk_val($sformatf("L%0d_c%0d_instr", k, c), instr_w[k], mem[m_pc[k][11:2]]);
                    chk_val($sformatf("L%0d_c%0d_pc", k, c), opc_w[k], m_pc[k]);
                end
                if (mode[k] == 2) chk_val($sformatf("L%0d_c%0d_err_pc", k, c), opc_w[k], last_acc[k]);
                if (k == act_lane) begin
                    if (cen_w[k]) begin s_cyc.push_back(c); s_addr.push_back(int'(addr_w[k])); end
                    if (valid_w[k] && ready[k]) begin a_cyc.push_back(c); a_pc.push_back(int'(opc_w[k])); end
                    if (valid_w[k] && !prev_v[k]) rise_cyc.push_back(c);
                    if (halted_w[k] && halt_cyc < 0) halt_cyc = c;
                end
                prev_v[k] = valid_w[k];
                if (mode[k] == 0) begin
                    if (c == strobe_at[k] && !legal(m_pc[k])) begin
                        mode[k] = 2;
                    end else if (e_valid && ready[k]) begin
                        last_acc[k] = m_pc[k];
                        if (mem[m_pc[k][11:2]][6:0] == 7'b1110011) begin
                            mode[k] = 1;
                        end else begin
                            m_pc[k] = rdv[k] ? rpc[k] : m_pc[k] + 32'd4;
                            strobe_at[k] = c + 1;
                        end
                    end
                end
            end
            rst_seen[k] = !rst_n[k];
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_base();
        for (int i = 0; i < 1024; i++) mem[i] = (32'(i) << 20) | 32'h0000_0013;
    endtask

    task automatic clear_logs();
        s_cyc.delete(); s_addr.delete(); a_cyc.delete(); a_pc.delete(); rise_cyc.delete();
        halt_cyc = -1;
    endtask

    task automatic lane_reset(input int k);
        for (int j = 0; j < NL; j++) begin
            rst_n[j] = 1'b0; ready[j] = 1'b0; rdv[j] = 1'b0; rpc[j] = '0;
        end
        act_lane = k;
        step(2);
        clear_logs();
        rst_n[k] = 1'b1;
    endtask

    task automatic err_case(input string nm, input logic [31:0] tgt, input int at,
                            input int n_str, input logic [31:0] last_pc);
        lane_reset(0);
        ready[0] = 1'b1;
        step(at);
        rdv[0] = 1'b1; rpc[0] = tgt;
        step(1);
        rdv[0] = 1'b0;
        step(10);
        chk_val({nm, "_strobes"}, s_cyc.size(), n_str);
        chk_val({nm, "_err"}, err_w[0], 1);
        chk_val({nm, "_halted"}, halted_w[0], 0);
        chk_val({nm, "_valid"}, valid_w[0], 0);
        chk_val({nm, "_last_pc"}, opc_w[0], last_pc);
    endtask

    int q[$];

    initial begin
        for (int j = 0; j < NL; j++) begin
            rst_n[j] = 1'b0; ready[j] = 1'b0; rdv[j] = 1'b0; rpc[j] = '0;
        end

        // straight-line program ending in EOF at 0xC
        load_base();
        mem[3] = 32'h0000_0073;
        lane_reset(0);
        ready[0] = 1'b1;
        step(20);
        q = '{1, 4, 7, 10};       chk_list("t1_strobe_cyc", s_cyc, q);
        q = '{0, 4, 8, 12};       chk_list("t1_strobe_addr", s_addr, q);
        q = '{0, 4, 8, 12};       chk_list("t1_acc_pc", a_pc, q);
        chk_val("t1_halt_cyc", halt_cyc, 13);
        chk_val("t1_halted", halted_w[0], 1);

        // backpressure on the word at 0x4
        load_base();
        lane_reset(0);
        ready[0] = 1'b1;
        step(4);
        ready[0] = 1'b0;
        step(7);
        ready[0] = 1'b1;
        step(6);
        q = '{1, 4, 12, 15};      chk_list("t2_strobe_cyc", s_cyc, q);
        q = '{0, 4, 8, 12};       chk_list("t2_strobe_addr", s_addr, q);
        q = '{3, 11, 14};         chk_list("t2_acc_cyc", a_cyc, q);
        q = '{0, 4, 8};           chk_list("t2_acc_pc", a_pc, q);

        // redirect at the accept of 0x8, then a stray pulse outside an accept
        lane_reset(0);
        ready[0] = 1'b1;
        step(9);
        rdv[0] = 1'b1; rpc[0] = 32'h40;
        step(1);
        rdv[0] = 1'b0;
        step(1);
        rdv[0] = 1'b1; rpc[0] = 32'h80;
        step(1);
        rdv[0] = 1'b0;
        step(4);
        q = '{1, 4, 7, 10, 13};   chk_list("t3_strobe_cyc", s_cyc, q);
        q = '{0, 4, 8, 64, 68};   chk_list("t3_strobe_addr", s_addr, q);

        // illegal targets
        err_case("t4_misaligned", 32'h42, 6, 2, 32'h4);
        err_case("t5_beyond", 32'h1000, 3, 1, 32'h0);
        err_case("t5_wrap_end", 32'hFFC, 3, 2, 32'hFFC);

        // reset during WAIT with RD_LAT=3
        lane_reset(1);
        ready[1] = 1'b1;
        step(7);
        q = '{1, 6};              chk_list("t6_pre_strobe_cyc", s_cyc, q);
        chk_val("t6_pre_instr", instr_w[1], 32'h0000_0013);
        rst_n[1] = 1'b0;
        step(1);
        chk_val("t6_rst_instr", instr_w[1], 0);
        chk_val("t6_rst_cen", cen_w[1], 0);
        step(1);
        clear_logs();
        rst_n[1] = 1'b1;
        step(12);
        q = '{1, 6, 11};          chk_list("t6_strobe_cyc", s_cyc, q);
        q = '{0, 4, 8};           chk_list("t6_strobe_addr", s_addr, q);
        q = '{5, 10};             chk_list("t6_rise_cyc", rise_cyc, q);
        q = '{0, 4};              chk_list("t6_acc_pc", a_pc, q);

        // RD_LAT=4 sweep to EOF at 0x14
        load_base();
        mem[5] = 32'h0000_0073;
        lane_reset(2);
        ready[2] = 1'b1;
        step(42);
        q = '{1, 7, 13, 19, 25, 31};         chk_list("t7_strobe_cyc", s_cyc, q);
        q = '{0, 4, 8, 12, 16, 20};          chk_list("t7_strobe_addr", s_addr, q);
        q = '{6, 12, 18, 24, 30, 36};        chk_list("t7_rise_cyc", rise_cyc, q);
        chk_val("t7_halt_cyc", halt_cyc, 37);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
